flag_status_latch: RTL and testbench
====================================

Name: flag_status_latch

Overview:
- Registered consumer of the ALU flag outputs.
- Samples the raw carry/borrow/overflow signals plus the 8-bit result on an execute strobe, and derives the C, B, V, Z and N flags from the operation select.
- Holds the flags under a valid/ack handshake toward the RPN control logic.
- Feeds the latched carry back as a carry-in for chained multi-byte adds, and stretches a capture pulse for the board LEDs.

Parameters:
- STRETCH, 8'd50, cycles LedAct stays high after each capture (1..255).
- SEL_ADD, 3'b000, Sel code whose Cout is valid.
- SEL_SUB, 3'b001, Sel code whose Bout is valid.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Exec  in  1  one-cycle strobe: ALU inputs and outputs valid this cycle.
- Sel  in  3  operation select of the executed op.
- Cout  in  1  ALU carry out.
- Bout  in  1  ALU borrow out.
- OvfIn  in  1  ALU signed overflow.
- Result  in  8  ALU result.
- Ack  in  1  consumer has read the flags.
- Clear  in  1  synchronous clear of flags and overrun.
- FlagC, FlagB, FlagV, FlagZ, FlagN  out  1 each  latched flags.
- FlagValid  out  1  flags held and unread.
- Overrun  out  1  sticky: a capture replaced unread flags.
- CarryIn  out  1  equals FlagC, for the next chained add.
- LedAct  out  1  stretched capture indicator.

Behaviour:
- Reset (async, Rst=1): all outputs 0; state IDLE; stretch counter 0.
- Flag derivation, evaluated in the Exec cycle:
  - C = Cout & (Sel==SEL_ADD).
  - B = Bout & (Sel==SEL_SUB).
  - V = OvfIn & (Sel==SEL_ADD | Sel==SEL_SUB).
  - Z = (Result==8'h00).
  - N = Result[7].
- Latency: flags registered on the Clk edge where Exec=1; visible, together with FlagValid=1, the following cycle.
- States: IDLE (FlagValid=0) and HOLD (FlagValid=1).
  - IDLE --Exec--> HOLD.
  - HOLD --Ack & !Exec--> IDLE.
  - HOLD --Exec--> HOLD, with new flags loaded.
  - If that Exec arrives without Ack in the same cycle, Overrun is set to 1.
  - Exec and Ack in the same cycle in HOLD: new flags loaded, stays HOLD, no overrun.
  - Ack in IDLE: ignored.
- Flags persist in IDLE after Ack. They are cleared only by Clear or reset.
- Clear (synchronous):
  - Zeroes flags, FlagValid and Overrun; forces IDLE.
  - Priority: Rst > Clear > Exec > Ack. Clear and Exec in the same cycle: the Exec is discarded.
- CarryIn is combinationally equal to FlagC, with no extra register.
- LedAct:
  - Each capture loads the counter with STRETCH; LedAct = (counter != 0); the counter decrements each cycle.
  - Back-to-back captures reload the counter without gaps.
  - Counter width is 8 bits, with no wrap: it holds at 0.
- Reset mid-HOLD returns to IDLE immediately, whatever Exec or Ack is doing.

Optional Feature:
- Macro FLAG_STICKY_EN.
  - Defined: C, B and V accumulate. Each capture ORs the new value into the held value; Z and N are still overwritten. Accumulated bits clear only on Clear or Rst. CarryIn still reflects the accumulated FlagC.
  - Undefined: every capture overwrites all five flags.

Test Plan:
- Rst pulse mid-HOLD -> all outputs 0 asynchronously, before the next edge; IDLE after release.
- Exec, Sel=000, Cout=1, Result=8'h00 -> next cycle: FlagC=1, FlagZ=1, FlagB=0, FlagValid=1, CarryIn=1, LedAct=1 for exactly 50 cycles.
- Exec, Sel=001, Bout=1, Cout=1, Result=8'h80, OvfIn=1 -> FlagB=1, FlagC=0, FlagN=1, FlagV=1. Then Exec, Sel=010, OvfIn=1 -> FlagV=0.
- Exec twice with no Ack between -> Overrun=1 and second flags held. Ack -> FlagValid=0, Overrun stays 1. Clear -> Overrun=0.
- In HOLD, Exec+Ack in the same cycle -> Overrun=0, FlagValid stays 1. Clear+Exec in the same cycle -> all flags 0, IDLE.
- With FLAG_STICKY_EN: add with Cout=1, then add with Cout=0 -> FlagC remains 1. Without the macro -> FlagC=0.

Source files
------------

// File: rtl/flag_status_latch.sv
// Registered ALU flag latch with valid/ack hand-off, chained-add carry feedback and LED pulse stretcher.
// Build option: define FLAG_STICKY_EN to make C, B and V accumulate across captures.
module flag_status_latch #(
    parameter logic [7:0] STRETCH = 8'd50,
    parameter logic [2:0] SEL_ADD = 3'b000,
    parameter logic [2:0] SEL_SUB = 3'b001
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Exec,
    input  logic [2:0] Sel,
    input  logic       Cout,
    input  logic       Bout,
    input  logic       OvfIn,
    input  logic [7:0] Result,
    input  logic       Ack,
    input  logic       Clear,
    output logic       FlagC,
    output logic       FlagB,
    output logic       FlagV,
    output logic       FlagZ,
    output logic       FlagN,
    output logic       FlagValid,
    output logic       Overrun,
    output logic       CarryIn,
    output logic       LedAct,
    output logic       DbgState
);

    // Handshake: FlagValid rises the cycle after an Exec capture and stays high
    // until Ack is seen while holding; a capture while FlagValid is high and
    // without a same-cycle Ack replaces unread flags and sets sticky Overrun.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       flag_c_q, flag_c_d;
    logic       flag_b_q, flag_b_d;
    logic       flag_v_q, flag_v_d;
    logic       flag_z_q, flag_z_d;
    logic       flag_n_q, flag_n_d;
    logic       overrun_q, overrun_d;
    logic [7:0] cnt_q, cnt_d;

    logic       new_c, new_b, new_v, new_z, new_n;
    logic       is_add, is_sub;

    assign is_add = (Sel == SEL_ADD);
    assign is_sub = (Sel == SEL_SUB);
    assign new_c  = Cout & is_add;
    assign new_b  = Bout & is_sub;
    assign new_v  = OvfIn & (is_add | is_sub);
    assign new_z  = (Result == 8'h00);
    assign new_n  = Result[7];

    always_comb begin
        state_d   = state_q;
        flag_c_d  = flag_c_q;
        flag_b_d  = flag_b_q;
        flag_v_d  = flag_v_q;
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        overrun_d = overrun_q;
        cnt_d     = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;

        if (Clear) begin
            // Clear outranks a same-cycle Exec, which is dropped entirely.
            state_d   = IDLE;
            flag_c_d  = 1'b0;
            flag_b_d  = 1'b0;
            flag_v_d  = 1'b0;
            flag_z_d  = 1'b0;
            flag_n_d  = 1'b0;
            overrun_d = 1'b0;
        end else if (Exec) begin
            state_d  = HOLD;
            cnt_d    = STRETCH;
`ifdef FLAG_STICKY_EN
            flag_c_d = flag_c_q | new_c;
            flag_b_d = flag_b_q | new_b;
            flag_v_d = flag_v_q | new_v;
`else
            flag_c_d = new_c;
            flag_b_d = new_b;
            flag_v_d = new_v;
`endif
            flag_z_d = new_z;
            flag_n_d = new_n;
            if ((state_q == HOLD) && !Ack) begin
                overrun_d = 1'b1;
            end
        end else if (Ack && (state_q == HOLD)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            flag_c_q  <= 1'b0;
            flag_b_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            flag_c_q  <= flag_c_d;
            flag_b_q  <= flag_b_d;
            flag_v_q  <= flag_v_d;
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
        end
    end

    assign FlagC     = flag_c_q;
    assign FlagB     = flag_b_q;
    assign FlagV     = flag_v_q;
    assign FlagZ     = flag_z_q;
    assign FlagN     = flag_n_q;
    assign FlagValid = (state_q == HOLD);
    assign Overrun   = overrun_q;
    // Carry feedback is the held flag itself, so a chained add sees it without delay.
    assign CarryIn   = flag_c_q;
    assign LedAct    = (cnt_q != 8'd0);
    assign DbgState  = state_q;

endmodule

// File: tb/tb_flag_status_latch.sv
// Self-checking bench for flag_status_latch: directed test-plan sequences followed by random traffic.
// Expected output words are queued when stimulus is driven and compared after the capturing edge.
module tb_flag_status_latch;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Exec = 1'b0;
    logic [2:0] Sel = 3'd0;
    logic       Cout = 1'b0;
    logic       Bout = 1'b0;
    logic       OvfIn = 1'b0;
    logic [7:0] Result = 8'd0;
    logic       Ack = 1'b0;
    logic       Clear = 1'b0;
    logic       FlagC, FlagB, FlagV, FlagZ, FlagN;
    logic       FlagValid, Overrun, CarryIn, LedAct, DbgState;

    flag_status_latch dut (
        .Clk(Clk), .Rst(Rst), .Exec(Exec), .Sel(Sel), .Cout(Cout), .Bout(Bout),
        .OvfIn(OvfIn), .Result(Result), .Ack(Ack), .Clear(Clear),
        .FlagC(FlagC), .FlagB(FlagB), .FlagV(FlagV), .FlagZ(FlagZ), .FlagN(FlagN),
        .FlagValid(FlagValid), .Overrun(Overrun), .CarryIn(CarryIn),
        .LedAct(LedAct), .DbgState(DbgState)
    );

    // Clock / reset
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: {C,B,V,Z,N,Valid,Overrun,CarryIn,LedAct,State}
    localparam int W = 10;
    logic [W-1:0] exp_q[$];

    // Reference model state
    logic       m_c, m_b, m_v, m_z, m_n, m_valid, m_ovr;
    int         m_cnt;

    function automatic logic [W-1:0] dut_word();
        return {FlagC, FlagB, FlagV, FlagZ, FlagN, FlagValid, Overrun, CarryIn, LedAct, DbgState};
    endfunction

    function automatic logic [W-1:0] model_word();
        return {m_c, m_b, m_v, m_z, m_n, m_valid, m_ovr, m_c, (m_cnt != 0), m_valid};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_c = 0; m_b = 0; m_v = 0; m_z = 0; m_n = 0;
        m_valid = 0; m_ovr = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic e, input logic [2:0] s, input logic co, input logic bo,
                              input logic ov, input logic [7:0] r, input logic a, input logic cl);
        logic nc, nb, nv;
        if (m_cnt > 0) m_cnt--;
        if (cl) begin
            m_c = 0; m_b = 0; m_v = 0; m_z = 0; m_n = 0; m_valid = 0; m_ovr = 0;
        end else if (e) begin
            nc = co && (s == 3'b000);
            nb = bo && (s == 3'b001);
            nv = ov && (s == 3'b000 || s == 3'b001);
`ifdef FLAG_STICKY_EN
            m_c = m_c | nc; m_b = m_b | nb; m_v = m_v | nv;
`else
            m_c = nc; m_b = nb; m_v = nv;
`endif
            m_z = (r == 8'h00);
            m_n = r[7];
            if (m_valid && !a) m_ovr = 1;
            m_valid = 1;
            m_cnt = 50;
        end else if (a) begin
            m_valid = 0;
        end
    endtask

    // Driver: apply one cycle of stimulus, push expectation, compare after the edge.
    task automatic step(input string tag, input logic e, input logic [2:0] s, input logic co,
                        input logic bo, input logic ov, input logic [7:0] r, input logic a,
                        input logic cl);
        logic [W-1:0] exp;
        @(negedge Clk);
        Exec = e; Sel = s; Cout = co; Bout = bo; OvfIn = ov; Result = r; Ack = a; Clear = cl;
        model_step(e, s, co, bo, ov, r, a, cl);
        exp_q.push_back(model_word());
        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check(tag, 32'(dut_word()), 32'(exp));
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 3'd0, 0, 0, 0, 8'h55, 0, 0);
    endtask

    initial begin
        int led_cycles;
        model_reset();
        #2;
        check("reset_outputs", 32'(dut_word()), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;

        // Add with carry, zero result; LED must stay high exactly 50 cycles.
        step("add_c_z", 1, 3'b000, 1, 0, 0, 8'h00, 0, 0);
        check("add_flagc", 32'(FlagC), 32'd1);
        check("add_carryin", 32'(CarryIn), 32'd1);
        led_cycles = LedAct ? 1 : 0;
        for (int i = 0; i < 59; i++) begin
            idle("led_idle");
            if (LedAct) led_cycles++;
        end
        check("led_stretch_len", 32'(led_cycles), 32'd50);

        step("ack1", 0, 3'd0, 0, 0, 0, 8'h00, 1, 0);
        check("ack_valid_low", 32'(FlagValid), 32'd0);
        check("flags_persist", 32'({FlagC, FlagZ}), 32'b11);

        // Subtract with borrow, negative result, overflow.
        step("sub_b_n_v", 1, 3'b001, 1, 1, 1, 8'h80, 1, 0);
        check("sub_fields", 32'({FlagC, FlagB, FlagV, FlagN}), 32'b0111);
        step("ack_sub", 0, 3'd0, 0, 0, 0, 8'h00, 1, 0);
        step("sel010_ovf", 1, 3'b010, 1, 1, 1, 8'h12, 1, 0);
        check("sel010_v0", 32'(FlagV), 32'd0);

        // Second capture without Ack -> overrun.
        step("overrun", 1, 3'b000, 0, 0, 0, 8'h7f, 0, 0);
        check("overrun_set", 32'(Overrun), 32'd1);
        step("ack_after_ovr", 0, 3'd0, 0, 0, 0, 8'h00, 1, 0);
        check("overrun_sticky", 32'({FlagValid, Overrun}), 32'b01);
        step("clear_ovr", 0, 3'd0, 0, 0, 0, 8'h00, 0, 1);
        check("clear_overrun", 32'(Overrun), 32'd0);

        // Exec with Ack while holding: no overrun.
        step("exec1", 1, 3'b000, 1, 0, 0, 8'h01, 0, 0);
        step("exec_ack", 1, 3'b001, 0, 1, 0, 8'h02, 1, 0);
        check("exec_ack_no_ovr", 32'({FlagValid, Overrun}), 32'b10);
        step("clear_exec", 1, 3'b000, 1, 0, 1, 8'h00, 0, 1);
        check("clear_exec_zero", 32'({FlagC, FlagB, FlagV, FlagZ, FlagN, FlagValid}), 32'd0);

        // Chained adds: carry then no carry.
        step("chain1", 1, 3'b000, 1, 0, 0, 8'h10, 0, 0);
        step("chain2", 1, 3'b000, 0, 0, 0, 8'h20, 1, 0);
`ifdef FLAG_STICKY_EN
        check("chain_sticky_c", 32'(FlagC), 32'd1);
`else
        check("chain_over_c", 32'(FlagC), 32'd0);
`endif

        // Async reset mid-HOLD, with Exec/Ack active.
        step("pre_rst", 1, 3'b000, 1, 0, 1, 8'h80, 0, 0);
        @(negedge Clk);
        Exec = 1; Ack = 1; Sel = 3'b000; Cout = 1; Result = 8'h00;
        #2;
        Rst = 1'b1;
        #1;
        check("async_rst", 32'(dut_word()), 32'd0);
        @(posedge Clk);
        #1;
        check("rst_held", 32'(dut_word()), 32'd0);
        @(negedge Clk);
        Rst = 1'b0; Exec = 0; Ack = 0;
        model_reset();
        idle("post_rst_idle");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 19) == 0));
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
